// File: rtl/julia_pkg.sv
// Shared constants, button FSM encoding and the Q4.12 wrap-step helper
// for the Julia parameter controller.
package julia_pkg;

    localparam int Q_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } btn_st_t;

    localparam logic signed [Q_W-1:0] C_STEP_DEF  = 16'sd64;
    localparam logic signed [Q_W-1:0] C_MIN_DEF   = -16'sd8192;
    localparam logic signed [Q_W-1:0] C_MAX_DEF   = 16'sd8191;
    localparam logic signed [Q_W-1:0] C_RE_DEF    = -16'sd3277;
    localparam logic signed [Q_W-1:0] C_IM_DEF    = 16'sd2785;
    localparam logic [3:0]            ZOOM_MAX_DEF = 4'd7;

    // Sum is formed one bit wider so overflow past C_MAX is seen before truncation.
    function automatic logic signed [Q_W-1:0] c_next(
        input logic signed [Q_W-1:0] cur,
        input logic signed [Q_W-1:0] step,
        input logic signed [Q_W-1:0] cmin,
        input logic signed [Q_W-1:0] cmax
    );
        logic signed [Q_W:0] sum;
        sum = $signed({cur[Q_W-1], cur}) + $signed({step[Q_W-1], step});
        if (sum > $signed({cmax[Q_W-1], cmax})) begin
            return cmin;
        end
        return sum[Q_W-1:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchronizer, then a level is accepted only after
// DEBOUNCE_CYCLES consecutive samples that differ from the current level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 742500
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/julia_param_ctrl.sv
// Button-driven Julia constant / zoom stepping, applied on v_sync rising edges.
// Define JULIA_AUTO_ANIM_EN to animate c_im after 64 idle frames.
module julia_param_ctrl
    import julia_pkg::*;
#(
    parameter int                     DEBOUNCE_CYCLES = 742500,
    parameter int                     REPEAT_FRAMES   = 8,
    parameter logic signed [Q_W-1:0]  C_STEP          = C_STEP_DEF,
    parameter logic signed [Q_W-1:0]  C_MIN           = C_MIN_DEF,
    parameter logic signed [Q_W-1:0]  C_MAX           = C_MAX_DEF,
    parameter logic signed [Q_W-1:0]  C_RE_INIT       = C_RE_DEF,
    parameter logic signed [Q_W-1:0]  C_IM_INIT       = C_IM_DEF,
    parameter logic [3:0]             ZOOM_MAX        = ZOOM_MAX_DEF
) (
    input  logic          i_pix_clk,
    input  logic          i_rst,
    input  logic          i_v_sync,
    input  logic [2:0]    i_btn,
    output logic [15:0]   o_c_re,
    output logic [15:0]   o_c_im,
    output logic [3:0]    o_zoom,
    output logic          o_update
);
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);

    logic [2:0]      w_deb;
    logic [2:0]      w_pend;
    logic            r_vs_prev;
    logic            w_frame;
    logic            w_upd;
    logic            w_step_im;
    btn_st_t         r_st [3];
    btn_st_t         w_st_nxt [3];
    logic [RW-1:0]   r_rep [3];
    logic [RW-1:0]   w_rep_nxt [3];
    logic [Q_W-1:0]  r_c_re;
    logic [Q_W-1:0]  r_c_im;
    logic [3:0]      r_zoom;
    logic            r_upd;

    for (genvar g = 0; g < 3; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk  (i_pix_clk),
            .i_rst  (i_rst),
            .i_btn  (i_btn[g]),
            .o_level(w_deb[g])
        );
    end

    assign w_frame = i_v_sync & ~r_vs_prev;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_st_nxt[i]  = r_st[i];
            w_rep_nxt[i] = r_rep[i];
            w_pend[i]    = (r_st[i] == ST_PEND);
            unique case (r_st[i])
                ST_IDLE: begin
                    if (w_deb[i]) w_st_nxt[i] = ST_PEND;
                end
                // A released button in PEND still gets its step.
                ST_PEND: begin
                    if (w_frame) begin
                        w_st_nxt[i]  = w_deb[i] ? ST_HOLD : ST_IDLE;
                        w_rep_nxt[i] = '0;
                    end
                end
                ST_HOLD: begin
                    if (!w_deb[i]) begin
                        w_st_nxt[i]  = ST_IDLE;
                        w_rep_nxt[i] = '0;
                    end else if (w_frame) begin
                        if ((r_rep[i] + 1'b1) >= REP_LAST) begin
                            w_st_nxt[i]  = ST_PEND;
                            w_rep_nxt[i] = '0;
                        end else begin
                            w_rep_nxt[i] = r_rep[i] + 1'b1;
                        end
                    end
                end
                default: w_st_nxt[i] = ST_IDLE;
            endcase
        end
    end

`ifdef JULIA_AUTO_ANIM_EN
    logic [6:0] r_idle;
    logic       w_anim;

    assign w_anim    = w_frame & (r_idle == 7'd64) & ~(|w_deb);
    assign w_step_im = w_pend[1] | w_anim;
    assign w_upd     = w_frame & ((|w_pend) | w_anim);

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle <= '0;
        end else if (|w_deb) begin
            r_idle <= '0;
        end else if (w_frame && r_idle != 7'd64) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_step_im = w_pend[1];
    assign w_upd     = w_frame & (|w_pend);
`endif

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_prev <= 1'b0;
            r_c_re    <= C_RE_INIT;
            r_c_im    <= C_IM_INIT;
            r_zoom    <= '0;
            r_upd     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_st[i]  <= ST_IDLE;
                r_rep[i] <= '0;
            end
        end else begin
            r_vs_prev <= i_v_sync;
            r_upd     <= w_upd;
            for (int i = 0; i < 3; i++) begin
                r_st[i]  <= w_st_nxt[i];
                r_rep[i] <= w_rep_nxt[i];
            end
            if (w_upd) begin
                if (w_pend[0]) r_c_re <= c_next(r_c_re, C_STEP, C_MIN, C_MAX);
                if (w_step_im) r_c_im <= c_next(r_c_im, C_STEP, C_MIN, C_MAX);
                if (w_pend[2]) r_zoom <= (r_zoom == ZOOM_MAX) ? 4'd0 : r_zoom + 4'd1;
            end
        end
    end

    assign o_c_re   = r_c_re;
    assign o_c_im   = r_c_im;
    assign o_zoom   = r_zoom;
    assign o_update = r_upd;

endmodule

// File: tb/tb_julia_param_ctrl.sv
// Bench for julia_param_ctrl: directed scenarios plus randomized
// press/hold sequences checked against a frame-level stepping model.
module tb_julia_param_ctrl;

    localparam int DEB   = 4;
    localparam int RPT   = 8;
    localparam int STEP  = 64;
    localparam int CMIN  = -8192;
    localparam int CMAX  = 8191;
    localparam int RE0   = -3277;
    localparam int IM0   = 2785;
    localparam int ZMAX  = 7;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_v_sync = 1'b0;
    logic [2:0]  i_btn = 3'b000;
    logic [15:0] o_c_re;
    logic [15:0] o_c_im;
    logic [3:0]  o_zoom;
    logic        o_update;

    int n_checks = 0;
    int n_fail = 0;
    int upd_cnt = 0;
    int m_re = RE0;
    int m_im = IM0;
    int m_zoom = 0;

    julia_param_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_FRAMES  (RPT)
    ) dut (
        .i_pix_clk(clk),
        .i_rst    (i_rst),
        .i_v_sync (i_v_sync),
        .i_btn    (i_btn),
        .o_c_re   (o_c_re),
        .o_c_im   (o_c_im),
        .o_zoom   (o_zoom),
        .o_update (o_update)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (o_update === 1'b1) upd_cnt++;
        end
    end

    function automatic int step_c(input int v);
        return (v + STEP > CMAX) ? CMIN : v + STEP;
    endfunction

    function automatic int step_z(input int z);
        return (z == ZMAX) ? 0 : z + 1;
    endfunction

    function automatic void model_steps(input logic [2:0] mask, input int n);
        for (int s = 0; s < n; s++) begin
            if (mask[0]) m_re = step_c(m_re);
            if (mask[1]) m_im = step_c(m_im);
            if (mask[2]) m_zoom = step_z(m_zoom);
        end
    endfunction

    task automatic frame();
        @(negedge clk) i_v_sync = 1'b1;
        @(negedge clk) i_v_sync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] mask);
        i_btn = i_btn | mask;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic press_bounce(input logic [2:0] mask);
        @(negedge clk) i_btn = i_btn | mask;
        @(negedge clk) i_btn = i_btn & ~mask;
        @(negedge clk) i_btn = i_btn | mask;
        @(negedge clk) i_btn = i_btn & ~mask;
        @(negedge clk) i_btn = i_btn | mask;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic release_btn(input logic [2:0] mask);
        i_btn = i_btn & ~mask;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic tap(input logic [2:0] mask);
        press(mask);
        frame();
        release_btn(mask);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_c_re !== 16'(RE0)) begin
            n_fail++;
            $display("FAIL rst_c_re got=%0d exp=%0d", $signed(o_c_re), RE0);
        end
        n_checks++;
        if (o_c_im !== 16'(IM0)) begin
            n_fail++;
            $display("FAIL rst_c_im got=%0d exp=%0d", $signed(o_c_im), IM0);
        end
        n_checks++;
        if (o_zoom !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_zoom got=%0d exp=0", o_zoom);
        end
        n_checks++;
        if (o_update !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_update got=%b exp=0", o_update);
        end
    endtask

    task automatic test_debounce();
        int u0;
        u0 = upd_cnt;
        press_bounce(3'b001);
        n_checks++;
        if (upd_cnt - u0 !== 0) begin
            n_fail++;
            $display("FAIL deb_no_frame_upd got=%0d exp=0", upd_cnt - u0);
        end
        frame();
        model_steps(3'b001, 1);
        n_checks++;
        if (upd_cnt - u0 !== 1) begin
            n_fail++;
            $display("FAIL deb_upd got=%0d exp=1", upd_cnt - u0);
        end
        n_checks++;
        if (o_c_re !== 16'(m_re) || m_re != -3213) begin
            n_fail++;
            $display("FAIL deb_c_re got=%0d exp=%0d", $signed(o_c_re), m_re);
        end
        release_btn(3'b001);
        u0 = upd_cnt;
        @(negedge clk) i_btn[1] = 1'b1;
        @(negedge clk);
        @(negedge clk) i_btn[1] = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        frame();
        n_checks++;
        if (upd_cnt - u0 !== 0 || o_c_im !== 16'(m_im)) begin
            n_fail++;
            $display("FAIL glitch upd=%0d c_im=%0d exp_upd=0 exp_c_im=%0d",
                     upd_cnt - u0, $signed(o_c_im), m_im);
        end
    endtask

    task automatic test_repeat();
        int u0;
        u0 = upd_cnt;
        press(3'b010);
        repeat (17) frame();
        model_steps(3'b010, 3);
        n_checks++;
        if (upd_cnt - u0 !== 3) begin
            n_fail++;
            $display("FAIL rep_upd got=%0d exp=3", upd_cnt - u0);
        end
        n_checks++;
        if (o_c_im !== 16'(m_im) || m_im != IM0 + 3 * STEP) begin
            n_fail++;
            $display("FAIL rep_c_im got=%0d exp=%0d", $signed(o_c_im), m_im);
        end
        release_btn(3'b010);
        u0 = upd_cnt;
        frame();
        n_checks++;
        if (upd_cnt - u0 !== 0) begin
            n_fail++;
            $display("FAIL rep_after_release got=%0d exp=0", upd_cnt - u0);
        end
    endtask

    task automatic test_late_press();
        int u0;
        u0 = upd_cnt;
        i_btn[0] = 1'b1;
        repeat (2) @(negedge clk);
        frame();
        n_checks++;
        if (upd_cnt - u0 !== 0) begin
            n_fail++;
            $display("FAIL late_first_frame got=%0d exp=0", upd_cnt - u0);
        end
        repeat (DEB + 4) @(negedge clk);
        frame();
        model_steps(3'b001, 1);
        n_checks++;
        if (upd_cnt - u0 !== 1 || o_c_re !== 16'(m_re)) begin
            n_fail++;
            $display("FAIL late_next_frame upd=%0d c_re=%0d exp_upd=1 exp_c_re=%0d",
                     upd_cnt - u0, $signed(o_c_re), m_re);
        end
        release_btn(3'b001);
    endtask

    task automatic test_wrap();
        bit wrapped = 0;
        for (int n = 0; n < 400 && !wrapped; n++) begin
            wrapped = (m_re + STEP > CMAX);
            tap(3'b001);
            model_steps(3'b001, 1);
            n_checks++;
            if (o_c_re !== 16'(m_re)) begin
                n_fail++;
                $display("FAIL wrap_c_re tap=%0d got=%0d exp=%0d", n, $signed(o_c_re), m_re);
            end
        end
        n_checks++;
        if (!wrapped || o_c_re !== 16'(CMIN)) begin
            n_fail++;
            $display("FAIL wrap_c_re_min got=%0d exp=%0d", $signed(o_c_re), CMIN);
        end
        wrapped = 0;
        for (int n = 0; n < 20 && !wrapped; n++) begin
            wrapped = (m_zoom == ZMAX);
            tap(3'b100);
            model_steps(3'b100, 1);
            n_checks++;
            if (o_zoom !== 4'(m_zoom)) begin
                n_fail++;
                $display("FAIL wrap_zoom tap=%0d got=%0d exp=%0d", n, o_zoom, m_zoom);
            end
        end
        n_checks++;
        if (!wrapped || o_zoom !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_zoom_zero got=%0d exp=0", o_zoom);
        end
    endtask

    task automatic test_simultaneous();
        int u0;
        u0 = upd_cnt;
        press_bounce(3'b101);
        frame();
        release_btn(3'b101);
        model_steps(3'b101, 1);
        n_checks++;
        if (upd_cnt - u0 !== 1) begin
            n_fail++;
            $display("FAIL simul_upd got=%0d exp=1", upd_cnt - u0);
        end
        n_checks++;
        if (o_c_re !== 16'(m_re) || o_zoom !== 4'(m_zoom) || o_c_im !== 16'(m_im)) begin
            n_fail++;
            $display("FAIL simul_vals got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     $signed(o_c_re), $signed(o_c_im), o_zoom, m_re, m_im, m_zoom);
        end
    endtask

    task automatic test_random();
        int u0, k, nsteps;
        logic [2:0] mask;
        for (int it = 0; it < 12; it++) begin
            mask = 3'($urandom_range(1, 7));
            k = int'($urandom_range(1, 17));
            nsteps = 1 + (k - 1) / RPT + ((k % RPT == 0) ? 1 : 0);
            u0 = upd_cnt;
            press_bounce(mask);
            repeat (k) frame();
            release_btn(mask);
            frame();
            model_steps(mask, nsteps);
            n_checks++;
            if (upd_cnt - u0 !== nsteps) begin
                n_fail++;
                $display("FAIL rnd_upd it=%0d mask=%b k=%0d got=%0d exp=%0d",
                         it, mask, k, upd_cnt - u0, nsteps);
            end
            n_checks++;
            if (o_c_re !== 16'(m_re) || o_c_im !== 16'(m_im) || o_zoom !== 4'(m_zoom)) begin
                n_fail++;
                $display("FAIL rnd_vals it=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", it,
                         $signed(o_c_re), $signed(o_c_im), o_zoom, m_re, m_im, m_zoom);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int u0;
        press(3'b001);
        frame();
        press(3'b010);
        i_btn[1] = 1'b0;
        @(negedge clk) i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        m_re = RE0;
        m_im = IM0;
        m_zoom = 0;
        u0 = upd_cnt;
        frame();
        n_checks++;
        if (upd_cnt - u0 !== 0) begin
            n_fail++;
            $display("FAIL rsthold_no_upd got=%0d exp=0", upd_cnt - u0);
        end
        n_checks++;
        if (o_c_re !== 16'(RE0) || o_c_im !== 16'(IM0) || o_zoom !== 4'd0) begin
            n_fail++;
            $display("FAIL rsthold_vals got=%0d/%0d/%0d exp=%0d/%0d/0",
                     $signed(o_c_re), $signed(o_c_im), o_zoom, RE0, IM0);
        end
        repeat (DEB + 6) @(negedge clk);
        frame();
        model_steps(3'b001, 1);
        n_checks++;
        if (upd_cnt - u0 !== 1 || o_c_re !== 16'(m_re) || o_c_im !== 16'(m_im)) begin
            n_fail++;
            $display("FAIL rsthold_repress upd=%0d c_re=%0d c_im=%0d exp_upd=1 exp=%0d/%0d",
                     upd_cnt - u0, $signed(o_c_re), $signed(o_c_im), m_re, m_im);
        end
        release_btn(3'b001);
    endtask

`ifdef JULIA_AUTO_ANIM_EN
    task automatic test_idle_frames();
        int u0;
        @(negedge clk) i_rst = 1'b1;
        @(negedge clk) i_rst = 1'b0;
        m_re = RE0;
        m_im = IM0;
        m_zoom = 0;
        u0 = upd_cnt;
        repeat (64) frame();
        n_checks++;
        if (upd_cnt - u0 !== 0) begin
            n_fail++;
            $display("FAIL anim_early got=%0d exp=0", upd_cnt - u0);
        end
        repeat (3) frame();
        model_steps(3'b010, 3);
        n_checks++;
        if (upd_cnt - u0 !== 3 || o_c_im !== 16'(m_im)) begin
            n_fail++;
            $display("FAIL anim_run upd=%0d c_im=%0d exp_upd=3 exp_c_im=%0d",
                     upd_cnt - u0, $signed(o_c_im), m_im);
        end
        u0 = upd_cnt;
        tap(3'b001);
        model_steps(3'b001, 1);
        repeat (3) frame();
        n_checks++;
        if (upd_cnt - u0 !== 1 || o_c_im !== 16'(m_im) || o_c_re !== 16'(m_re)) begin
            n_fail++;
            $display("FAIL anim_stop upd=%0d c=%0d/%0d exp_upd=1 exp=%0d/%0d",
                     upd_cnt - u0, $signed(o_c_re), $signed(o_c_im), m_re, m_im);
        end
    endtask
`else
    task automatic test_idle_frames();
        int u0;
        u0 = upd_cnt;
        repeat (70) frame();
        n_checks++;
        if (upd_cnt - u0 !== 0 || o_c_im !== 16'(m_im)) begin
            n_fail++;
            $display("FAIL idle_no_anim upd=%0d c_im=%0d exp_upd=0 exp_c_im=%0d",
                     upd_cnt - u0, $signed(o_c_im), m_im);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_debounce();
        test_repeat();
        test_late_press();
        test_wrap();
        test_simultaneous();
        test_random();
        test_reset_mid_hold();
        test_idle_frames();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
